// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request FSM feeding a small
// instruction FIFO, with redirect flush and halt gating of new requests.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned DEPTH    = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_rdata,
    output logic       inst_valid,
    input  logic       inst_ready,
    output logic [7:0] inst_data,
    output logic [7:0] inst_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    input  logic       halt
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    localparam logic [1:0] LAST = 2'(DEPTH - 1);
    localparam logic [2:0] CAP  = 3'(DEPTH);

    state_t     r_state;
    logic [7:0] r_fetch_pc;
    logic [7:0] r_buf_data [4];
    logic [7:0] r_buf_pc   [4];
    logic [1:0] r_head;
    logic [1:0] r_tail;
    logic [2:0] r_count;

    logic       w_pop;
    logic       w_ack;
    logic       w_push;
    logic       w_issue;
    logic [2:0] w_count_nxt;
    logic [7:0] w_pc_nxt;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign inst_valid = (r_count != 3'd0);
    assign inst_data  = r_buf_data[r_head];
    assign inst_pc    = r_buf_pc[r_head];

    // Issue decision looks at the occupancy after this cycle's push/pop/flush.
    always_comb begin
        w_pop  = inst_valid & inst_ready;
        w_ack  = (r_state != IDLE) & imem_ack;
        w_push = (r_state == REQ) & imem_ack & ~redirect;
        if (redirect) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
        w_pc_nxt = r_fetch_pc;
        if (redirect) begin
            w_pc_nxt = redirect_pc;
        end else if (w_push) begin
            w_pc_nxt = imem_addr + 8'd1;
        end
        w_issue = ~halt & (w_count_nxt < CAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else begin
            r_fetch_pc <= w_pc_nxt;
            r_count    <= w_count_nxt;

            if (redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) begin
                    r_buf_data[r_tail] <= imem_rdata;
                    r_buf_pc[r_tail]   <= imem_addr;
                    r_tail             <= ptr_inc(r_tail);
                end
                if (w_pop) begin
                    r_head <= ptr_inc(r_head);
                end
            end

            // Any completed request (kept or drained) re-evaluates issue exactly like IDLE.
            case (r_state)
                IDLE, REQ, DRAIN: begin
                    if (r_state == IDLE || w_ack) begin
                        if (w_issue) begin
                            r_state   <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= w_pc_nxt;
                        end else begin
                            r_state  <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end else if (r_state == REQ && redirect) begin
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model; a second
// instance with RESET_PC=FE streams from zero-wait memory to cover pc wraparound.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] data;
    } ent_t;

    logic       clk;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       inst_valid;
    logic       inst_ready;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;

    logic       fe_req;
    logic [7:0] fe_addr;
    logic [7:0] fe_rdata;
    logic       fe_valid;
    logic [7:0] fe_data;
    logic [7:0] fe_pc;

    assign fe_rdata = fe_addr ^ 8'hA5;

    fetch_unit #(.RESET_PC(8'h00), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    fetch_unit #(.RESET_PC(8'hFE), .DEPTH(4)) dut_fe (
        .clk(clk), .reset(reset),
        .imem_req(fe_req), .imem_addr(fe_addr),
        .imem_ack(1'b1), .imem_rdata(fe_rdata),
        .inst_valid(fe_valid), .inst_ready(1'b1),
        .inst_data(fe_data), .inst_pc(fe_pc),
        .redirect(1'b0), .redirect_pc(8'h00), .halt(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: buffered instructions, outstanding request, discard flag, next fetch pc.
    ent_t       m_q[$];
    bit         m_out;
    bit         m_disc;
    logic [7:0] m_addr;
    logic [7:0] m_fpc;
    logic [7:0] fe_next;
    int         fe_cyc;

    // Memory behaviour: 0 = zero-wait, 1 = fixed latency, 2 = random latency.
    int mode;
    int mem_age;
    int mem_lat;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out   = 1'b0;
        m_disc  = 1'b0;
        m_addr  = 8'h00;
        m_fpc   = 8'h00;
        mem_age = 0;
        fe_next = 8'hFE;
        fe_cyc  = 0;
    endtask

    task automatic model_edge();
        bit   acked;
        ent_t e;
        acked = m_out && imem_ack;
        if (acked) begin
            mem_age = 0;
            if (mode == 2) mem_lat = $urandom_range(0, 3);
        end else if (m_out) begin
            mem_age++;
        end
        if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
        if (redirect) begin
            m_q.delete();
            m_fpc = redirect_pc;
            if (m_out && !imem_ack) m_disc = 1'b1;
        end else if (acked && !m_disc) begin
            e.pc   = m_addr;
            e.data = m_addr ^ 8'hA5;
            m_q.push_back(e);
            m_fpc = m_addr + 8'd1;
        end
        if (acked) begin
            m_out  = 1'b0;
            m_disc = 1'b0;
        end
        if (!m_out && !halt && m_q.size() < DEPTH) begin
            m_out  = 1'b1;
            m_addr = m_fpc;
        end
        fe_cyc++;
    endtask

    task automatic compare();
        check_eq("imem_req", 16'(imem_req), 16'(m_out));
        if (m_out) check_eq("imem_addr", 16'(imem_addr), 16'(m_addr));
        check_eq("inst_valid", 16'(inst_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("inst_pc", 16'(inst_pc), 16'(m_q[0].pc));
            check_eq("inst_data", 16'(inst_data), 16'(m_q[0].data));
        end
        if (fe_cyc >= 2) check_eq("fe_valid", 16'(fe_valid), 16'h1);
        if (fe_valid) begin
            check_eq("fe_pc", 16'(fe_pc), 16'(fe_next));
            check_eq("fe_data", 16'(fe_data), 16'(fe_next ^ 8'hA5));
            fe_next = fe_next + 8'd1;
        end
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [7:0] rpc,
                        input bit hlt, input bit force_ack);
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        halt        = hlt;
        if (force_ack || mode == 0) imem_ack = 1'b1;
        else                        imem_ack = m_out && (mem_age >= mem_lat);
        imem_rdata = imem_ack ? (imem_addr ^ 8'hA5) : 8'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        halt        = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 8'h00;
        #1;
        check_eq("rst_req", 16'(imem_req), 16'h0);
        check_eq("rst_addr", 16'(imem_addr), 16'h0);
        check_eq("rst_valid", 16'(inst_valid), 16'h0);
        check_eq("rst_data", 16'(inst_data), 16'h0);
        check_eq("rst_pc", 16'(inst_pc), 16'h0);
        check_eq("rst_fe_valid", 16'(fe_valid), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int         n;
        bit         rdy;
        bit         rd;
        bit         hl;
        logic [7:0] rpc;
        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        mem_lat  = 0;
        model_reset();
        do_reset();

        // Zero-wait streaming, then backpressure and release.
        repeat (12) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("bp_req_dropped", 16'(imem_req), 16'h0);
        repeat (8) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Latency-3 memory, redirect to 40 one cycle after the request to 05.
        mode    = 1;
        mem_lat = 2;
        step(1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        n = 0;
        while (!(m_out && m_addr == 8'h05) && n < 20) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        check_eq("req_05_addr", 16'(imem_addr), 16'h05);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
        check_eq("drain_addr", 16'(imem_addr), 16'h05);
        n = 0;
        while (!inst_valid && n < 20) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        check_eq("redir_first_pc", 16'(inst_pc), 16'h40);
        repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Halt with one entry buffered and one request outstanding.
        step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
        n = 0;
        while (!(m_q.size() == 1 && m_out) && n < 20) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("halt_req", 16'(imem_req), 16'h0);
        check_eq("halt_head_pc", 16'(inst_pc), 16'h80);
        repeat (8) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with wraparound-biased redirect targets.
        mode    = 2;
        mem_lat = 1;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            hl  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            step(rdy, rd, rpc, hl, 1'b0);
        end

        // Reset while a request is outstanding; a late ack lands in IDLE.
        mode    = 1;
        mem_lat = 3;
        n = 0;
        while (!m_out && n < 20) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        check_eq("pre_rst_req", 16'(imem_req), 16'h1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_req", 16'(imem_req), 16'h0);
        check_eq("async_rst_valid", 16'(inst_valid), 16'h0);
        #2;
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("late_ack_addr", 16'(imem_addr), 16'h00);
        check_eq("late_ack_valid", 16'(inst_valid), 16'h0);
        repeat (10) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
